// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, state encoding and counter sizing for the async SRAM controller
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } sram_state_t;

    // Wide enough to hold WAIT_CYCLES itself, so any legal strobe length fits.
    function automatic int wait_cnt_w(input int wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_heartbeat.sv
// rtl/sram_heartbeat.sv - free-running counter whose MSB blinks the board LED
module sram_heartbeat #(
    parameter int CTR_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic led
);

    logic [CTR_BITS-1:0] ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + 1'b1;
        end
    end

    assign led = ctr[CTR_BITS-1];

endmodule

// File: rtl/sram_1m_x8.sv
// rtl/sram_1m_x8.sv - single-request controller sequencing CE#/OE#/WE# for an async 1M x 8 SRAM
module sram_1m_x8
    import sram_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int WAIT_CYCLES  = 2,
    parameter int LED_CTR_BITS = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_led
);

    localparam int               CNT_W    = wait_cnt_w(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_t      state;
    logic [CNT_W-1:0] cnt;

    // Every pin toward the SRAM is a flop output, so strobes never glitch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_ready      <= 1'b1;
            o_done       <= 1'b0;
            o_rdata      <= '0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        o_ready     <= 1'b0;
                        o_sram_addr <= i_addr;
                        o_sram_ce_n <= 1'b0;
                        cnt         <= CNT_LOAD;
                        if (i_we) begin
                            o_sram_dq    <= i_wdata;
                            o_sram_dq_oe <= 1'b1;
                            state        <= WR_SETUP;
                        end else begin
                            o_sram_oe_n <= 1'b0;
                            state       <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        o_rdata     <= i_sram_dq;
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        o_done      <= 1'b1;
                        o_ready     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    o_sram_we_n <= 1'b0;
                    cnt         <= CNT_LOAD;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        o_sram_we_n <= 1'b1;
                        state       <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    o_sram_ce_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    o_done       <= 1'b1;
                    o_ready      <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sram_heartbeat #(
        .CTR_BITS(LED_CTR_BITS)
    ) u_heartbeat (
        .clk  (i_clk),
        .rst_n(i_reset_n),
        .led  (o_led)
    );

endmodule

// File: tb/tb_sram_1m_x8.sv
// tb/tb_sram_1m_x8.sv - scoreboard bench with SRAM pin model and reference memory for sram_1m_x8
module tb_sram_1m_x8;

    localparam int AW = 20;
    localparam int DW = 8;
    localparam int W  = 2;
    localparam int LB = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;

    logic          o_ready, o_done, o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_led;
    logic [DW-1:0] o_rdata, o_sram_dq, sram_q;
    logic [AW-1:0] o_sram_addr;

    sram_1m_x8 #(
        .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .LED_CTR_BITS(LB)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_sram_addr (o_sram_addr),
        .o_sram_dq   (o_sram_dq),
        .o_sram_dq_oe(o_sram_dq_oe),
        .i_sram_dq   (sram_q),
        .o_sram_ce_n (o_sram_ce_n),
        .o_sram_oe_n (o_sram_oe_n),
        .o_sram_we_n (o_sram_we_n),
        .o_led       (o_led)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM pin model: latches on the WE# rising edge, drives only under CE# & OE#.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];

    always @(posedge o_sram_we_n) begin
        if (!o_sram_ce_n) sram_mem[o_sram_addr] <= o_sram_dq;
    end

    always_comb begin
        sram_q = 8'hEE;
        if (!o_sram_ce_n && !o_sram_oe_n) sram_q = sram_mem[o_sram_addr];
    end

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            done_cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem[int];
    logic [AW-1:0] wr_list[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int inv_err  = 0;
    int ce_lo = 0, oe_lo = 0, we_lo = 0, dq_drv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req_v, cyc);
        end
    endtask

    task automatic access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", int'(o_ready), 1);
        if (!o_ready) begin
            req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        e.is_rd    = !w;
        e.addr     = a;
        e.done_cyc = cyc + (w ? W + 2 : W);
        if (w) begin
            e.data     = d;
            ref_mem[a] = d;
            wr_list.push_back(a);
        end else begin
            e.data = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: tracks strobe occupancy per access and scores each o_done against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ce_lo = 0; oe_lo = 0; we_lo = 0; dq_drv = 0;
            end else begin
                if (!o_sram_ce_n) ce_lo++;
                if (!o_sram_oe_n) oe_lo++;
                if (!o_sram_we_n) we_lo++;
                if (o_sram_dq_oe) dq_drv++;
                if (!o_sram_oe_n && o_sram_dq_oe) begin
                    inv_err++;
                    $display("FAIL oe_with_dq_drive at cycle %0d", cyc);
                end
                if (!o_sram_ce_n && (exp_q.size() == 0 || o_sram_addr != exp_q[0].addr)) begin
                    inv_err++;
                    $display("FAIL addr_unstable actual=0x%0h at cycle %0d", o_sram_addr, cyc);
                end
                if (o_sram_dq_oe && (exp_q.size() == 0 || o_sram_dq != exp_q[0].data)) begin
                    inv_err++;
                    $display("FAIL dq_unstable actual=0x%0h at cycle %0d", o_sram_dq, cyc);
                end
                if (o_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        if (e.is_rd) begin
                            chk("rdata", int'(o_rdata), int'(e.data));
                            chk("rd_ce_low_cycles", ce_lo, W);
                            chk("rd_oe_low_cycles", oe_lo, W);
                            chk("rd_we_low_cycles", we_lo, 0);
                            chk("rd_dq_oe_cycles", dq_drv, 0);
                        end else begin
                            chk("wr_ce_low_cycles", ce_lo, W + 2);
                            chk("wr_oe_low_cycles", oe_lo, 0);
                            chk("wr_we_low_cycles", we_lo, W);
                            chk("wr_dq_oe_cycles", dq_drv, W + 2);
                        end
                    end
                    ce_lo = 0; oe_lo = 0; we_lo = 0; dq_drv = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;

        #23;
        chk("rst_ce_n", int'(o_sram_ce_n), 1);
        chk("rst_oe_n", int'(o_sram_oe_n), 1);
        chk("rst_we_n", int'(o_sram_we_n), 1);
        chk("rst_dq_oe", int'(o_sram_dq_oe), 0);
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_done", int'(o_done), 0);
        chk("rst_led", int'(o_led), 0);
        chk("rst_addr", int'(o_sram_addr), 0);
        chk("rst_dq", int'(o_sram_dq), 0);
        chk("rst_rdata", int'(o_rdata), 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("led_after_%0d", k), int'(o_led), ((k % 16) >= 8) ? 1 : 0);
        end

        access(1'b1, 20'h12345, 8'hA5);
        access(1'b0, 20'h12345, 8'h00);

        // Busy request held through a write: accepted on the edge after ready returns.
        access(1'b1, 20'h0ABCD, 8'h11);
        n = cyc;
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 20'h00001; wdata = 8'h3C;
        e.is_rd    = 1'b0;
        e.addr     = 20'h00001;
        e.data     = 8'h3C;
        e.done_cyc = n + (W + 3) + (W + 2);
        exp_q.push_back(e);
        ref_mem[1] = 8'h3C;
        wr_list.push_back(20'h00001);
        repeat (W + 3) @(posedge clk);
        #1;
        req = 1'b0;
        access(1'b0, 20'h00001, 8'h00);
        access(1'b0, 20'h0ABCD, 8'h00);

        // Asynchronous reset during the WE# pulse.
        access(1'b1, 20'h77777, 8'h99);
        void'(wr_list.pop_back());
        ref_mem.delete(32'h77777);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("we_n_in_pulse", int'(o_sram_we_n), 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_we_n", int'(o_sram_we_n), 1);
        chk("abort_ce_n", int'(o_sram_ce_n), 1);
        chk("abort_dq_oe", int'(o_sram_dq_oe), 0);
        chk("abort_ready", int'(o_ready), 1);
        chk("abort_done", int'(o_done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        access(1'b1, 20'hFFFFF, 8'h5A);
        access(1'b1, 20'h00000, 8'hC3);
        access(1'b0, 20'hFFFFF, 8'h00);
        access(1'b0, 20'h00000, 8'h00);
        access(1'b0, 20'h12345, 8'h00);

        for (int i = 0; i < 40; i++) begin
            bit            w;
            logic [AW-1:0] a;
            w = (wr_list.size() == 0) || ($urandom_range(1, 0) == 1);
            if (w) begin
                a = AW'($urandom);
                if (a == 20'h77777) a = 20'h77776;
                access(1'b1, a, DW'($urandom));
            end else begin
                a = wr_list[$urandom_range(wr_list.size() - 1, 0)];
                access(1'b0, a, 8'h00);
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("strobe_invariant_errors", inv_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
